// File: rtl/uart_pkg.sv
// Constants and state encoding shared by the UART transmitter and receiver.
// Both ends of the link must agree on framing, so they live in one place.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 10416;
  localparam int DATA_BITS            = 8;
  localparam int BIT_IDX_W            = $clog2(DATA_BITS);

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_e;

  // Count at which the start bit is re-checked: the middle of the bit.
  function automatic int half_bit_last(input int clks_per_bit);
    return clks_per_bit / 2 - 1;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte-side interface of the UART receiver: valid/ready holding register
// plus the framing-error and overrun status flags.
interface uart_rx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output data_out,
    output data_valid,
    output frame_err,
    output overrun,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    input  frame_err,
    input  overrun,
    output data_ready
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous RxD line. Resets to the idle
// (high) level so a reset never manufactures a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic [1:0] r_sync;

  // NOTE: clocked state uses non-blocking assignments so both flops sample
  // their inputs from before the edge, giving a true two-stage shift.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_async};
    end
  end

  assign o_sync = r_sync[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised RxD, mid-bit sampling, stop-bit check,
// and a one-entry valid/ready holding register with overrun flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,  // minimum 4
  parameter int CNT_W        = 14                     // 2**CNT_W > CLKS_PER_BIT
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      RxD,
  uart_rx_if.master bus
);

  localparam logic [CNT_W-1:0]     LP_HALF_LAST = CNT_W'(half_bit_last(CLKS_PER_BIT));
  localparam logic [CNT_W-1:0]     LP_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_IDX_W-1:0] LP_IDX_LAST  = BIT_IDX_W'(DATA_BITS - 1);

  logic w_rx_s;

  rx_state_e              r_state,   w_state_nxt;
  logic [CNT_W-1:0]       r_cnt,     w_cnt_nxt;
  logic [BIT_IDX_W-1:0]   r_bit_idx, w_bit_idx_nxt;
  logic [DATA_BITS-1:0]   r_shift,   w_shift_nxt;
  logic                   w_byte_done;
  logic                   w_frame_bad;

  logic [DATA_BITS-1:0]   r_data_out;
  logic                   r_data_valid;
  logic                   r_frame_err;
  logic                   r_overrun;

  uart_rx_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (RxD),
    .o_sync  (w_rx_s)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_byte_done   = 1'b0;
    w_frame_bad   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_rx_s == START_BIT) w_state_nxt = ST_START;
      end

      ST_START: begin
        if (r_cnt == LP_HALF_LAST) begin
          w_cnt_nxt     = '0;
          w_bit_idx_nxt = '0;
          w_state_nxt   = (w_rx_s == START_BIT) ? ST_DATA : ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (r_cnt == LP_BIT_LAST) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
          if (r_bit_idx == LP_IDX_LAST) begin
            w_state_nxt = ST_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + BIT_IDX_W'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      ST_STOP: begin
        if (r_cnt == LP_BIT_LAST) begin
          w_cnt_nxt = '0;
          if (w_rx_s == STOP_BIT) begin
            w_byte_done = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_frame_bad = 1'b1;
            w_state_nxt = ST_WAIT_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      // A held-low line (break) must not be re-read as a string of starts.
      ST_WAIT_IDLE: begin
        w_cnt_nxt = '0;
        if (w_rx_s == STOP_BIT) w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Holding register: a new byte may replace one being consumed this cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_err <= w_frame_bad;
      if (w_byte_done) begin
        if (!r_data_valid || bus.data_ready) begin
          r_data_out   <= r_shift;
          r_data_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_data_valid && bus.data_ready) begin
        r_data_valid <= 1'b0;
      end
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.data_valid = r_data_valid;
  assign bus.frame_err  = r_frame_err;
  assign bus.overrun    = r_overrun;

endmodule
